freq_track_ctrl: RTL and testbench
==================================

Name: freq_track_ctrl

Overview:
- Closed-loop frequency tracker that sits directly downstream of the FFT phase-difference stage.
- Consumes the signed voltage/current phase difference (phase_fft) and produces drive_frequency for the drive/DDS block.
- Runs a coarse sweep until the phase falls inside a capture window, then runs a proportional tracking loop with lock/loss detection.
- Enabled by the MCU enable strobe.

Parameters:
- F_MIN, 20000, lowest drive frequency (Hz).
- F_MAX, 60000, highest drive frequency (Hz).
- F_START, 20000, frequency after reset, idle or fault.
- F_STEP, 100, sweep increment per phase sample.
- PHASE_SET, 0, phase setpoint (LSB = 0.01 deg).
- SWEEP_WIN, 1000, |phase| at or below this value ends the sweep.
- KP_SHIFT, 4, proportional gain = 2^-KP_SHIFT.
- MAX_DELTA, 200, clamp on the per-sample correction.
- LOCK_TOL, 200; LOCK_CNT, 8, lock criterion.
- LOSS_TOL, 3000; LOSS_CNT, 4, loss-of-lock criterion.
- MAX_WRAPS, 3, sweep wrap-arounds allowed before fault.

Ports:
- clk_100M  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- en  in  1  tracking enable (level).
- phase_fft  in  16  signed phase difference, V minus I.
- phase_valid  in  1  one-cycle strobe qualifying phase_fft.
- drive_frequency  out  32  unsigned drive frequency (Hz).
- freq_update  out  1  one-cycle pulse when drive_frequency changes value or is rewritten.
- locked  out  1  loop locked.
- fault  out  1  sweep exhausted without capture.
- state  out  2  00 IDLE, 01 SWEEP, 10 TRACK, 11 FAULT.

Behaviour:
- Reset (asynchronous, immediate, also mid-operation): drive_frequency=F_START, freq_update=0, locked=0, fault=0, state=IDLE, wrap counter=0, lock/loss counters=0, pipeline valids cleared.
- Pipeline:
  - Stage 1 (edge after phase_valid): err = phase_fft - PHASE_SET, computed at 17 bits signed; |err| at 17 bits unsigned, so -32768 is handled.
  - Stage 2: state action, drive_frequency write and freq_update pulse.
  - Latency: phase_valid in cycle n gives the update at the edge ending cycle n+1, visible in cycle n+2.
  - Back-to-back valids are accepted; samples are applied in order.
- Correction:
  - delta = err >>> KP_SHIFT (arithmetic, floor toward minus infinity).
  - Clamp delta to [-MAX_DELTA, +MAX_DELTA].
- IDLE:
  - drive_frequency holds. Samples are ignored.
  - en=1 -> SWEEP. Entering SWEEP from IDLE loads F_START and clears the wrap counter.
- SWEEP, per sample:
  - If |err| <= SWEEP_WIN -> TRACK; frequency unchanged, freq_update=1, counters cleared.
  - Else if freq + F_STEP > F_MAX: freq = F_MIN, wrap counter +1.
    - If the counter reaches MAX_WRAPS -> FAULT: fault=1, freq=F_START.
  - Else freq += F_STEP.
- TRACK, per sample:
  - freq = sat(freq + delta, F_MIN, F_MAX), computed at 33 bits signed before saturation.
  - |err| <= LOCK_TOL: lock count +1, loss count cleared. On reaching LOCK_CNT, locked=1 (count saturates).
  - |err| > LOSS_TOL: loss count +1, lock count cleared. On reaching LOSS_CNT: locked=0, go to SWEEP from the current freq; the wrap counter is NOT cleared.
  - Otherwise (between the tolerances): lock count cleared; loss count cleared; locked holds.
- FAULT:
  - Holds F_START and fault=1.
  - Exited only by en=0 -> IDLE, which clears fault.
- en=0 in any state:
  - Next edge -> IDLE, locked=0, fault=0.
  - In-flight pipeline samples are discarded. drive_frequency holds, freq_update=0.
- Simultaneous events:
  - en falling in the same cycle as a stage-2 sample: en wins, no update.
  - Lock and loss conditions are mutually exclusive by tolerance ordering (LOCK_TOL < LOSS_TOL is required; parameter check at elaboration).
- freq_update pulses for every stage-2 sample processed in SWEEP/TRACK, and on SWEEP entry from IDLE.

Decomposition:
- Package ft_pkg holds:
  - state encoding constants (IDLE/SWEEP/TRACK/FAULT);
  - phase/frequency width constants (16, 32);
  - the default parameter values.
- One sub-module, ft_err_calc (stage 1): subtract setpoint, absolute value, arithmetic shift, clamp. Registered outputs err_abs, delta, valid.
- FSM, counters and frequency saturation stay in freq_track_ctrl.

Test Plan:
- Reset and enable: assert rst mid-run -> drive_frequency=20000, locked=0, fault=0, state=00 immediately. Release rst, en=1 -> state=01, freq_update pulse.
- Sweep stepping: SWEEP, 3 samples phase=5000 -> drive_frequency 20100, 20200, 20300, each appearing 2 cycles after its strobe. Then phase=800 -> state=10, freq stays 20300.
- Tracking arithmetic, in TRACK at freq=40000:
  - phase=1600 -> 40100;
  - phase=16000 -> clamped to 40300;
  - phase=-17 -> delta=-2, 40298;
  - at freq=59950, phase=3200 -> saturates to 60000.
- Lock and loss:
  - 8 samples phase=100 -> locked=1 after the 8th.
  - 3 samples phase=5000 -> still locked.
  - 4th sample -> locked=0, state=01.
- Wrap and fault: SWEEP with constant phase=5000 -> 60000 wraps to 20000, wrap count 1. At the 3rd wrap -> state=11, fault=1, freq=20000. en=0 -> state=00, fault=0.
- en drop mid-pipeline: phase_valid, then en=0 the next cycle -> no freq_update, drive_frequency unchanged, state=00.

Source files
------------

// File: rtl/ft_pkg.sv
// Shared widths, state encoding and default tuning values for the frequency tracker.
package ft_pkg;

  localparam int PHASE_W = 16;
  localparam int FREQ_W  = 32;
  localparam int ERR_W   = PHASE_W + 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_SWEEP = 2'b01,
    ST_TRACK = 2'b10,
    ST_FAULT = 2'b11
  } ft_state_e;

  localparam int DEF_F_MIN     = 20000;
  localparam int DEF_F_MAX     = 60000;
  localparam int DEF_F_START   = 20000;
  localparam int DEF_F_STEP    = 100;
  localparam int DEF_PHASE_SET = 0;
  localparam int DEF_SWEEP_WIN = 1000;
  localparam int DEF_KP_SHIFT  = 4;
  localparam int DEF_MAX_DELTA = 200;
  localparam int DEF_LOCK_TOL  = 200;
  localparam int DEF_LOCK_CNT  = 8;
  localparam int DEF_LOSS_TOL  = 3000;
  localparam int DEF_LOSS_CNT  = 4;
  localparam int DEF_MAX_WRAPS = 3;

endpackage

// File: rtl/ft_err_calc.sv
// Stage 1 of the tracker: phase error against the setpoint, its magnitude,
// and the clamped proportional correction, all registered.
module ft_err_calc
  import ft_pkg::*;
#(
  parameter int PHASE_SET = DEF_PHASE_SET,
  parameter int KP_SHIFT  = DEF_KP_SHIFT,
  parameter int MAX_DELTA = DEF_MAX_DELTA
) (
  input  logic                    clk_100M,
  input  logic                    rst,
  input  logic                    en,
  input  logic [PHASE_W-1:0]      phase_fft,
  input  logic                    phase_valid,
  output logic [ERR_W-1:0]        err_abs,
  output logic signed [ERR_W-1:0] delta,
  output logic                    valid
);

  localparam logic signed [ERR_W-1:0] SET_C  = ERR_W'(PHASE_SET);
  localparam logic signed [ERR_W-1:0] DMAX_C = ERR_W'(MAX_DELTA);
  localparam logic signed [ERR_W-1:0] DMIN_C = -DMAX_C;

  logic signed [ERR_W-1:0] err;
  logic signed [ERR_W-1:0] shifted;
  logic signed [ERR_W-1:0] clamped;
  logic        [ERR_W-1:0] mag;

  // One extra bit keeps -32768 minus the setpoint and its magnitude exact.
  always_comb begin
    err     = $signed({phase_fft[PHASE_W-1], phase_fft}) - SET_C;
    mag     = err[ERR_W-1] ? $unsigned(-err) : $unsigned(err);
    shifted = err >>> KP_SHIFT;
    clamped = shifted;
    if (shifted > DMAX_C)      clamped = DMAX_C;
    else if (shifted < DMIN_C) clamped = DMIN_C;
  end

  // NOTE: clocked state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk_100M or posedge rst) begin
    if (rst) begin
      valid   <= 1'b0;
      err_abs <= '0;
      delta   <= '0;
    end else begin
      valid <= phase_valid & en;
      if (phase_valid) begin
        err_abs <= mag;
        delta   <= clamped;
      end
    end
  end

endmodule

// File: rtl/freq_track_ctrl.sv
// Closed-loop drive-frequency tracker: coarse sweep until the phase enters the
// capture window, then proportional tracking with lock and loss detection.
module freq_track_ctrl
  import ft_pkg::*;
#(
  parameter int F_MIN     = DEF_F_MIN,
  parameter int F_MAX     = DEF_F_MAX,
  parameter int F_START   = DEF_F_START,
  parameter int F_STEP    = DEF_F_STEP,
  parameter int PHASE_SET = DEF_PHASE_SET,
  parameter int SWEEP_WIN = DEF_SWEEP_WIN,
  parameter int KP_SHIFT  = DEF_KP_SHIFT,
  parameter int MAX_DELTA = DEF_MAX_DELTA,
  parameter int LOCK_TOL  = DEF_LOCK_TOL,
  parameter int LOCK_CNT  = DEF_LOCK_CNT,
  parameter int LOSS_TOL  = DEF_LOSS_TOL,
  parameter int LOSS_CNT  = DEF_LOSS_CNT,
  parameter int MAX_WRAPS = DEF_MAX_WRAPS
) (
  input  logic               clk_100M,
  input  logic               rst,
  input  logic               en,
  input  logic [PHASE_W-1:0] phase_fft,
  input  logic               phase_valid,
  output logic [FREQ_W-1:0]  drive_frequency,
  output logic               freq_update,
  output logic               locked,
  output logic               fault,
  output logic [1:0]         state
);

  if (LOCK_TOL >= LOSS_TOL) begin : g_tol_check
    $error("freq_track_ctrl: LOCK_TOL must be below LOSS_TOL");
  end

  localparam int FX_W   = FREQ_W + 1;
  localparam int LOCK_W = $clog2(LOCK_CNT + 1);
  localparam int LOSS_W = $clog2(LOSS_CNT + 1);
  localparam int WRAP_W = $clog2(MAX_WRAPS + 1);

  localparam logic [FREQ_W-1:0]      F_START_F = FREQ_W'(F_START);
  localparam logic [FREQ_W-1:0]      F_MIN_F   = FREQ_W'(F_MIN);
  localparam logic [FREQ_W-1:0]      F_MAX_F   = FREQ_W'(F_MAX);
  localparam logic [FX_W-1:0]        F_STEP_X  = FX_W'(F_STEP);
  localparam logic [FX_W-1:0]        F_MAX_X   = FX_W'(F_MAX);
  localparam logic signed [FX_W-1:0] F_MIN_S   = FX_W'(F_MIN);
  localparam logic signed [FX_W-1:0] F_MAX_S   = FX_W'(F_MAX);
  localparam logic [ERR_W-1:0]       SWEEP_WIN_C = ERR_W'(SWEEP_WIN);
  localparam logic [ERR_W-1:0]       LOCK_TOL_C  = ERR_W'(LOCK_TOL);
  localparam logic [ERR_W-1:0]       LOSS_TOL_C  = ERR_W'(LOSS_TOL);
  localparam logic [LOCK_W-1:0]      LOCK_CNT_C  = LOCK_W'(LOCK_CNT);
  localparam logic [LOSS_W-1:0]      LOSS_CNT_C  = LOSS_W'(LOSS_CNT);
  localparam logic [WRAP_W-1:0]      MAX_WRAPS_C = WRAP_W'(MAX_WRAPS);

  logic [ERR_W-1:0]        s1_err_abs;
  logic signed [ERR_W-1:0] s1_delta;
  logic                    s1_valid;

  ft_err_calc #(
    .PHASE_SET (PHASE_SET),
    .KP_SHIFT  (KP_SHIFT),
    .MAX_DELTA (MAX_DELTA)
  ) u_err_calc (
    .clk_100M    (clk_100M),
    .rst         (rst),
    .en          (en),
    .phase_fft   (phase_fft),
    .phase_valid (phase_valid),
    .err_abs     (s1_err_abs),
    .delta       (s1_delta),
    .valid       (s1_valid)
  );

  ft_state_e         state_q, state_d;
  logic [FREQ_W-1:0] freq_q, freq_d;
  logic              upd_q, upd_d;
  logic              locked_q, locked_d;
  logic              fault_q, fault_d;
  logic [WRAP_W-1:0] wraps_q, wraps_d, wraps_inc;
  logic [LOCK_W-1:0] lock_cnt_q, lock_cnt_d, lock_cnt_inc;
  logic [LOSS_W-1:0] loss_cnt_q, loss_cnt_d, loss_cnt_inc;

  logic [FX_W-1:0]        swp_sum;
  logic signed [FX_W-1:0] trk_sum;
  logic [FREQ_W-1:0]      freq_trk;

  assign wraps_inc    = wraps_q + WRAP_W'(1);
  assign lock_cnt_inc = lock_cnt_q + LOCK_W'(1);
  assign loss_cnt_inc = loss_cnt_q + LOSS_W'(1);

  // Both sums carry one extra bit so overflow past F_MAX or below zero is visible.
  assign swp_sum = {1'b0, freq_q} + F_STEP_X;
  assign trk_sum = $signed({1'b0, freq_q})
                 + $signed({{(FX_W-ERR_W){s1_delta[ERR_W-1]}}, s1_delta});

  always_comb begin
    freq_trk = trk_sum[FREQ_W-1:0];
    if (trk_sum < F_MIN_S)      freq_trk = F_MIN_F;
    else if (trk_sum > F_MAX_S) freq_trk = F_MAX_F;
  end

  // NOTE: every signal driven here gets a default first, so no path leaves
  // one unassigned and no latch is inferred.
  always_comb begin
    state_d    = state_q;
    freq_d     = freq_q;
    upd_d      = 1'b0;
    locked_d   = locked_q;
    fault_d    = fault_q;
    wraps_d    = wraps_q;
    lock_cnt_d = lock_cnt_q;
    loss_cnt_d = loss_cnt_q;

    if (!en) begin
      // Dropping enable overrides any sample arriving in the same cycle.
      state_d  = ST_IDLE;
      locked_d = 1'b0;
      fault_d  = 1'b0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          state_d = ST_SWEEP;
          freq_d  = F_START_F;
          wraps_d = '0;
          upd_d   = 1'b1;
        end
        ST_SWEEP: begin
          if (s1_valid) begin
            upd_d = 1'b1;
            if (s1_err_abs <= SWEEP_WIN_C) begin
              state_d    = ST_TRACK;
              lock_cnt_d = '0;
              loss_cnt_d = '0;
            end else if (swp_sum > F_MAX_X) begin
              freq_d  = F_MIN_F;
              wraps_d = wraps_inc;
              if (wraps_inc == MAX_WRAPS_C) begin
                state_d = ST_FAULT;
                fault_d = 1'b1;
                freq_d  = F_START_F;
              end
            end else begin
              freq_d = swp_sum[FREQ_W-1:0];
            end
          end
        end
        ST_TRACK: begin
          if (s1_valid) begin
            upd_d  = 1'b1;
            freq_d = freq_trk;
            if (s1_err_abs <= LOCK_TOL_C) begin
              loss_cnt_d = '0;
              if (lock_cnt_q != LOCK_CNT_C) lock_cnt_d = lock_cnt_inc;
              if (lock_cnt_d == LOCK_CNT_C) locked_d = 1'b1;
            end else if (s1_err_abs > LOSS_TOL_C) begin
              lock_cnt_d = '0;
              loss_cnt_d = loss_cnt_inc;
              if (loss_cnt_inc == LOSS_CNT_C) begin
                // Resume sweeping from here; the wrap budget keeps counting.
                locked_d   = 1'b0;
                state_d    = ST_SWEEP;
                loss_cnt_d = '0;
              end
            end else begin
              lock_cnt_d = '0;
              loss_cnt_d = '0;
            end
          end
        end
        ST_FAULT: begin
          fault_d = 1'b1;
          freq_d  = F_START_F;
        end
      endcase
    end
  end

  always_ff @(posedge clk_100M or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      freq_q     <= F_START_F;
      upd_q      <= 1'b0;
      locked_q   <= 1'b0;
      fault_q    <= 1'b0;
      wraps_q    <= '0;
      lock_cnt_q <= '0;
      loss_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      freq_q     <= freq_d;
      upd_q      <= upd_d;
      locked_q   <= locked_d;
      fault_q    <= fault_d;
      wraps_q    <= wraps_d;
      lock_cnt_q <= lock_cnt_d;
      loss_cnt_q <= loss_cnt_d;
    end
  end

  assign drive_frequency = freq_q;
  assign freq_update     = upd_q;
  assign locked          = locked_q;
  assign fault           = fault_q;
  assign state           = state_q;

endmodule

// File: tb/tb_freq_track_ctrl.sv
// Self-checking bench for freq_track_ctrl: directed sequences, a vector table,
// and randomized traffic compared cycle by cycle against a sample-level model.
module tb_freq_track_ctrl;

  logic        clk_100M = 1'b0;
  logic        rst;
  logic        en;
  logic [15:0] phase_fft;
  logic        phase_valid;
  logic [31:0] drive_frequency;
  logic        freq_update;
  logic        locked;
  logic        fault;
  logic [1:0]  state;

  always #5 clk_100M = ~clk_100M;

  freq_track_ctrl dut (
    .clk_100M        (clk_100M),
    .rst             (rst),
    .en              (en),
    .phase_fft       (phase_fft),
    .phase_valid     (phase_valid),
    .drive_frequency (drive_frequency),
    .freq_update     (freq_update),
    .locked          (locked),
    .fault           (fault),
    .state           (state)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: modes use the port encoding 0 idle, 1 sweep, 2 track, 3 fault.
  int       m_mode, m_freq, m_wraps, m_lock, m_loss, m_pend_ph;
  bit       m_locked, m_fault, m_upd, m_pend_v;

  task automatic model_reset();
    m_mode = 0; m_freq = 20000; m_wraps = 0; m_lock = 0; m_loss = 0;
    m_locked = 0; m_fault = 0; m_upd = 0; m_pend_v = 0; m_pend_ph = 0;
  endtask

  function automatic int corr(input int err);
    int d;
    d = (err >= 0) ? err / 16 : -((-err + 15) / 16);
    if (d > 200)  d = 200;
    if (d < -200) d = -200;
    return d;
  endfunction

  task automatic apply_sample(input int ph);
    int a;
    a = (ph < 0) ? -ph : ph;
    if (m_mode == 1) begin
      if (a <= 1000) begin
        m_mode = 2; m_lock = 0; m_loss = 0;
      end else if (m_freq + 100 > 60000) begin
        m_freq = 20000;
        m_wraps++;
        if (m_wraps >= 3) begin m_mode = 3; m_fault = 1; m_freq = 20000; end
      end else begin
        m_freq += 100;
      end
    end else begin
      m_freq += corr(ph);
      if (m_freq < 20000) m_freq = 20000;
      if (m_freq > 60000) m_freq = 60000;
      if (a <= 200) begin
        m_loss = 0;
        if (m_lock < 8) m_lock++;
        if (m_lock == 8) m_locked = 1;
      end else if (a > 3000) begin
        m_lock = 0;
        m_loss++;
        if (m_loss == 4) begin m_locked = 0; m_mode = 1; m_loss = 0; end
      end else begin
        m_lock = 0; m_loss = 0;
      end
    end
  endtask

  task automatic model_edge(input bit e, input bit pv, input int ph);
    m_upd = 0;
    if (!e) begin
      m_mode = 0; m_locked = 0; m_fault = 0;
    end else if (m_mode == 0) begin
      m_mode = 1; m_freq = 20000; m_wraps = 0; m_upd = 1;
    end else if (m_pend_v && (m_mode == 1 || m_mode == 2)) begin
      m_upd = 1;
      apply_sample(m_pend_ph);
    end
    m_pend_v  = pv & e;
    m_pend_ph = ph;
  endtask

  // One clock cycle: drive inputs just after an edge, advance the model at the
  // next edge, then compare all outputs 1 ns later.
  task automatic step(input bit e, input bit pv, input int ph);
    en = e; phase_valid = pv; phase_fft = 16'(ph);
    @(posedge clk_100M);
    model_edge(e, pv, ph);
    #1;
    check("freq",   drive_frequency,    32'(m_freq));
    check("upd",    32'(freq_update),   32'(m_upd));
    check("locked", 32'(locked),        32'(m_locked));
    check("fault",  32'(fault),         32'(m_fault));
    check("state",  32'(state),         32'(m_mode));
  endtask

  task automatic do_reset();
    rst = 1'b1; en = 1'b0; phase_valid = 1'b0;
    #1;
    check("rst_freq",   drive_frequency,  32'd20000);
    check("rst_upd",    32'(freq_update), 32'd0);
    check("rst_locked", 32'(locked),      32'd0);
    check("rst_fault",  32'(fault),       32'd0);
    check("rst_state",  32'(state),       32'd0);
    model_reset();
    @(posedge clk_100M);
    #1;
    rst = 1'b0;
  endtask

  // Reset, enable, sweep n samples then capture: leaves TRACK at 20000+100*n.
  task automatic setup_track(input int n);
    do_reset();
    step(1, 0, 0);
    repeat (n) step(1, 1, 5000);
    step(1, 1, 800);
    step(1, 0, 0);
    check("setup_freq",  drive_frequency, 32'(20000 + 100 * n));
    check("setup_state", 32'(state),      32'd2);
  endtask

  typedef struct {
    int         sweeps;
    int         phase;
    int         exp_freq;
    bit         exp_locked;
    logic [1:0] exp_state;
  } vec_t;

  vec_t vecs[$];

  initial begin
    rst = 1'b1; en = 1'b0; phase_valid = 1'b0; phase_fft = '0;
    model_reset();

    vecs.push_back('{200, 1600, 40100, 1'b0, 2'b10});
    vecs.push_back('{-1, 16000, 40300, 1'b0, 2'b10});
    vecs.push_back('{-1, -17,   40298, 1'b0, 2'b10});
    vecs.push_back('{399, 800,  59950, 1'b0, 2'b10});
    vecs.push_back('{-1, 3200,  60000, 1'b0, 2'b10});
    for (int i = 0; i < 7; i++) vecs.push_back('{-1, 100, 60000, 1'b0, 2'b10});
    vecs.push_back('{-1, 100, 60000, 1'b1, 2'b10});
    for (int i = 0; i < 3; i++) vecs.push_back('{-1, 5000, 60000, 1'b1, 2'b10});
    vecs.push_back('{-1, 5000, 60000, 1'b0, 2'b01});

    do_reset();

    // Idle holds, then enable enters SWEEP with an update pulse.
    step(0, 1, 5000);
    step(0, 0, 0);
    check("idle_state", 32'(state), 32'd0);
    step(1, 0, 0);
    check("entry_state", 32'(state),       32'd1);
    check("entry_upd",   32'(freq_update), 32'd1);

    // Sweep stepping: each result appears two cycles after its strobe.
    for (int k = 1; k <= 3; k++) begin
      step(1, 1, 5000);
      check("sweep_pre",  drive_frequency, 32'(20000 + 100 * (k - 1)));
      step(1, 0, 0);
      check("sweep_post", drive_frequency, 32'(20000 + 100 * k));
      check("sweep_upd",  32'(freq_update), 32'd1);
    end
    step(1, 1, 800);
    step(1, 0, 0);
    check("capture_state", 32'(state),     32'd2);
    check("capture_freq",  drive_frequency, 32'd20300);

    // Reset asserted mid-run takes effect without a clock edge.
    do_reset();
    step(1, 0, 0);
    check("reentry_state", 32'(state), 32'd1);

    // Tracking arithmetic, saturation, lock and loss.
    foreach (vecs[i]) begin
      if (vecs[i].sweeps >= 0) setup_track(vecs[i].sweeps);
      step(1, 1, vecs[i].phase);
      step(1, 0, 0);
      check($sformatf("vec%0d_freq", i),   drive_frequency,  32'(vecs[i].exp_freq));
      check($sformatf("vec%0d_locked", i), 32'(locked),      32'(vecs[i].exp_locked));
      check($sformatf("vec%0d_state", i),  32'(state),       32'(vecs[i].exp_state));
      check($sformatf("vec%0d_upd", i),    32'(freq_update), 32'd1);
    end

    // Wrap-around from 60000 and fault on the third wrap.
    step(1, 1, 5000);
    step(1, 0, 0);
    check("wrap1_freq",  drive_frequency, 32'd20000);
    check("wrap1_state", 32'(state),      32'd1);
    repeat (802) step(1, 1, 5000);
    step(1, 0, 0);
    check("fault_state", 32'(state),      32'd3);
    check("fault_flag",  32'(fault),      32'd1);
    check("fault_freq",  drive_frequency, 32'd20000);
    step(1, 1, 5000);
    step(1, 1, 300);
    step(1, 0, 0);
    check("fault_hold", 32'(state), 32'd3);
    step(0, 0, 0);
    check("fault_clr_state", 32'(state), 32'd0);
    check("fault_clr_flag",  32'(fault), 32'd0);

    // Enable dropped while a sample is in flight.
    step(1, 0, 0);
    step(1, 1, 5000);
    step(0, 0, 0);
    check("drop_upd",   32'(freq_update), 32'd0);
    check("drop_freq",  drive_frequency,  32'd20000);
    check("drop_state", 32'(state),       32'd0);
    step(0, 0, 0);
    check("drop_upd2", 32'(freq_update), 32'd0);

    // Randomized traffic against the model.
    for (int c = 0; c < 4000; c++) begin
      int ph;
      bit e, pv;
      e  = ($urandom_range(0, 59) != 0);
      pv = ($urandom_range(0, 2) != 0);
      case ($urandom_range(0, 4))
        0:       ph = int'($urandom_range(0, 600)) - 300;
        1:       ph = int'($urandom_range(0, 2000)) - 1000;
        2:       ph = int'($urandom_range(0, 8000)) - 4000;
        3:       ph = int'($urandom_range(0, 65535)) - 32768;
        default: ph = ($urandom_range(0, 1) != 0) ? 32767 : -32768;
      endcase
      step(e, pv, ph);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
